// File: rtl/network_ctrl_pkg.sv
// Shared types, widths and configuration address map for the network sequencer.
package network_ctrl_pkg;

  localparam int unsigned W  = 16;
  localparam int unsigned NI = 2;
  localparam int unsigned NH = 2;
  localparam int unsigned NO = 2;

  localparam int unsigned CFG_DEPTH = NH * NI + NH + NO * NH + NO;
  localparam int unsigned AW        = $clog2(CFG_DEPTH);

  localparam int unsigned HL_W_BASE = 0;
  localparam int unsigned HL_B_BASE = NH * NI;
  localparam int unsigned OL_W_BASE = HL_B_BASE + NH;
  localparam int unsigned OL_B_BASE = OL_W_BASE + NO * NH;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    HOLD
  } seq_state_t;

endpackage

// File: rtl/network_weight_bank.sv
// Configuration storage for the NETWORK datapath: flat word array with address
// decode, range check and a one-cycle reject pulse for dropped writes.
module network_weight_bank
   import network_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                we,
   input  logic [AW-1:0]       addr,
   input  logic signed [W-1:0] wdata,
   output logic                err,
   output logic signed [W-1:0] hl_weights [NH*NI],
   output logic signed [W-1:0] hl_bias    [NH],
   output logic signed [W-1:0] ol_weights [NO*NH],
   output logic signed [W-1:0] ol_bias    [NO]
);

   logic signed [W-1:0] mem [CFG_DEPTH];
   logic                in_range;
   logic                accept;

   assign in_range = ({1'b0, addr} < (AW + 1)'(CFG_DEPTH));
   assign accept   = we && en && in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < CFG_DEPTH; i++) mem[i] <= '0;
         err <= 1'b0;
      end else begin
         err <= we && !accept;
         if (accept) mem[addr] <= wdata;
      end
   end

   // Flat map is node-major, matching the datapath port ordering.
   always_comb begin
      for (int unsigned i = 0; i < NH * NI; i++) hl_weights[i] = mem[HL_W_BASE + i];
      for (int unsigned i = 0; i < NH; i++)      hl_bias[i]    = mem[HL_B_BASE + i];
      for (int unsigned i = 0; i < NO * NH; i++) ol_weights[i] = mem[OL_W_BASE + i];
      for (int unsigned i = 0; i < NO; i++)      ol_bias[i]    = mem[OL_B_BASE + i];
   end

endmodule

// File: rtl/network_sequencer.sv
// Sequencer between the stream fabric and the NETWORK datapath: owns config storage,
// launches one inference per accepted vector and returns the result with a timeout.
module network_sequencer
   import network_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                CLK,
   input  logic                RSTN,
   input  logic                CFG_WE,
   input  logic [AW-1:0]       CFG_ADDR,
   input  logic signed [W-1:0] CFG_WDATA,
   output logic                CFG_ERR,
   input  logic                S_VALID,
   output logic                S_READY,
   input  logic signed [W-1:0] S_DATA         [NI],
   output logic                M_VALID,
   input  logic                M_READY,
   output logic signed [W-1:0] M_DATA         [NO],
   output logic signed [W-1:0] NET_VALUES_IN  [NI],
   output logic                NET_VALID_IN,
   output logic signed [W-1:0] NET_HL_WEIGHTS [NH*NI],
   output logic signed [W-1:0] NET_HL_BIAS    [NH],
   output logic signed [W-1:0] NET_OL_WEIGHTS [NO*NH],
   output logic signed [W-1:0] NET_OL_BIAS    [NO],
   input  logic signed [W-1:0] NET_VALUES_OUT [NO],
   input  logic                NET_VALID_OUT,
   output logic                BUSY,
   output logic                ERR_TIMEOUT,
   input  logic                ERR_CLEAR
);

   localparam int unsigned   TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   seq_state_t    state;
   logic [TW-1:0] timer;

   network_weight_bank u_bank (
      .clk        (CLK),
      .rst_n      (RSTN),
      .en         (state == IDLE),
      .we         (CFG_WE),
      .addr       (CFG_ADDR),
      .wdata      (CFG_WDATA),
      .err        (CFG_ERR),
      .hl_weights (NET_HL_WEIGHTS),
      .hl_bias    (NET_HL_BIAS),
      .ol_weights (NET_OL_WEIGHTS),
      .ol_bias    (NET_OL_BIAS)
   );

   // Handshake outputs are registered alongside the state so none is combinational.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state         <= IDLE;
         timer         <= '0;
         S_READY       <= 1'b1;
         BUSY          <= 1'b0;
         NET_VALID_IN  <= 1'b0;
         M_VALID       <= 1'b0;
         ERR_TIMEOUT   <= 1'b0;
         NET_VALUES_IN <= '{default: '0};
         M_DATA        <= '{default: '0};
      end else begin
         NET_VALID_IN <= 1'b0;
         if (ERR_CLEAR) ERR_TIMEOUT <= 1'b0;
         unique case (state)
            IDLE: begin
               if (S_VALID) begin
                  NET_VALUES_IN <= S_DATA;
                  NET_VALID_IN  <= 1'b1;
                  S_READY       <= 1'b0;
                  BUSY          <= 1'b1;
                  state         <= LAUNCH;
               end
            end
            LAUNCH: begin
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               // A result on the expiry cycle beats the timeout.
               if (NET_VALID_OUT) begin
                  M_DATA  <= NET_VALUES_OUT;
                  M_VALID <= 1'b1;
                  state   <= HOLD;
               end else if (timer == TLAST) begin
                  ERR_TIMEOUT <= 1'b1;
                  S_READY     <= 1'b1;
                  BUSY        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            HOLD: begin
               if (M_READY) begin
                  M_VALID <= 1'b0;
                  S_READY <= 1'b1;
                  BUSY    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_network_sequencer.sv
// Bench for network_sequencer: table-driven config writes, scoreboarded inferences
// against a latency-programmable datapath stand-in, and hand-built corner sequences.
module tb_network_sequencer;
   import network_ctrl_pkg::*;

   typedef logic [255:0] wide_t;
   typedef logic [NI*W-1:0] vec_t;
   typedef struct {
      logic [AW-1:0] addr;
      logic [W-1:0]  data;
      logic          err;
   } cfg_vec_t;

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic                cfg_we = 1'b0;
   logic [AW-1:0]       cfg_addr = '0;
   logic signed [W-1:0] cfg_wdata = '0;
   logic                cfg_err;
   logic                s_valid = 1'b0;
   logic                s_ready;
   logic signed [W-1:0] s_data [NI];
   logic                m_valid;
   logic                m_ready = 1'b1;
   logic signed [W-1:0] m_data [NO];
   logic signed [W-1:0] net_values_in [NI];
   logic                net_valid_in;
   logic signed [W-1:0] net_hl_w [NH*NI];
   logic signed [W-1:0] net_hl_b [NH];
   logic signed [W-1:0] net_ol_w [NO*NH];
   logic signed [W-1:0] net_ol_b [NO];
   logic signed [W-1:0] net_values_out [NO];
   logic                net_valid_out = 1'b0;
   logic                busy;
   logic                err_timeout;
   logic                err_clear = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   wide_t sb [$];
   logic signed [W-1:0] sh [CFG_DEPTH];
   int cyc = 0;
   int lat = 4;
   int target = -1;
   bit inject = 1'b0;
   logic signed [W-1:0] pend [NO];

   always #5 clk = ~clk;

   network_sequencer #(.TIMEOUT_CYCLES(8)) dut (
      .CLK(clk), .RSTN(rstn),
      .CFG_WE(cfg_we), .CFG_ADDR(cfg_addr), .CFG_WDATA(cfg_wdata), .CFG_ERR(cfg_err),
      .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data),
      .M_VALID(m_valid), .M_READY(m_ready), .M_DATA(m_data),
      .NET_VALUES_IN(net_values_in), .NET_VALID_IN(net_valid_in),
      .NET_HL_WEIGHTS(net_hl_w), .NET_HL_BIAS(net_hl_b),
      .NET_OL_WEIGHTS(net_ol_w), .NET_OL_BIAS(net_ol_b),
      .NET_VALUES_OUT(net_values_out), .NET_VALID_OUT(net_valid_out),
      .BUSY(busy), .ERR_TIMEOUT(err_timeout), .ERR_CLEAR(err_clear)
   );

   // Datapath stand-in: answers lat cycles after NET_VALID_IN (lat 0 = never).
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      net_valid_out <= 1'b0;
      if (inject) begin
         net_valid_out <= 1'b1;
         for (int o = 0; o < NO; o++) net_values_out[o] <= W'(32'h5A5A + o);
      end
      if (target == cyc) begin
         net_valid_out  <= 1'b1;
         net_values_out <= pend;
         target         <= -1;
      end
      if (net_valid_in && lat > 0) begin
         for (int o = 0; o < NO; o++)
            pend[o] <= net_ol_b[o] + net_values_in[o % NI] + net_hl_w[o];
         target <= cyc + lat;
      end
   end

   task automatic chk(input string name, input wide_t act, input wide_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic wide_t exp_res(input vec_t v);
      wide_t r = '0;
      for (int o = 0; o < NO; o++)
         r[o*W +: W] = sh[OL_B_BASE + o] + v[(o % NI)*W +: W] + sh[HL_W_BASE + o];
      return r;
   endfunction

   function automatic wide_t m_pack();
      wide_t r = '0;
      for (int o = 0; o < NO; o++) r[o*W +: W] = m_data[o];
      return r;
   endfunction

   function automatic wide_t in_pack();
      wide_t r = '0;
      for (int i = 0; i < NI; i++) r[i*W +: W] = net_values_in[i];
      return r;
   endfunction

   function automatic wide_t dut_cfg();
      wide_t r = '0;
      for (int i = 0; i < NH*NI; i++) r[(HL_W_BASE + i)*W +: W] = net_hl_w[i];
      for (int i = 0; i < NH; i++)    r[(HL_B_BASE + i)*W +: W] = net_hl_b[i];
      for (int i = 0; i < NO*NH; i++) r[(OL_W_BASE + i)*W +: W] = net_ol_w[i];
      for (int i = 0; i < NO; i++)    r[(OL_B_BASE + i)*W +: W] = net_ol_b[i];
      return r;
   endfunction

   function automatic wide_t sh_pack();
      wide_t r = '0;
      for (int i = 0; i < CFG_DEPTH; i++) r[i*W +: W] = sh[i];
      return r;
   endfunction

   // Scoreboard: one pop per output handshake.
   always @(negedge clk) begin
      if (rstn && m_valid && m_ready) begin
         if (sb.size() == 0) chk("unexpected_m_valid", wide_t'(1), wide_t'(0));
         else chk("m_data", m_pack(), sb.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic launch(input vec_t v, input bit push);
      chk("s_ready_before_launch", wide_t'(s_ready), wide_t'(1));
      s_valid = 1'b1;
      for (int i = 0; i < NI; i++) s_data[i] = v[i*W +: W];
      if (push) sb.push_back(exp_res(v));
      tick();
      s_valid = 1'b0;
   endtask

   task automatic wait_mv(input int exp_n, input string name);
      int n = 0;
      int extra = 0;
      while (!m_valid && n < 60) begin
         tick();
         n++;
         if (net_valid_in) extra++;
      end
      chk(name, wide_t'(n), wide_t'(exp_n));
      chk({name, "_nvi_once"}, wide_t'(extra), wide_t'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cfg_vec_t tbl [8];
      int hs [3];
      int mv;
      int n;
      vec_t v;
      wide_t expv;

      for (int i = 0; i < NI; i++) s_data[i] = '0;
      for (int i = 0; i < CFG_DEPTH; i++) sh[i] = '0;

      tbl[0] = '{AW'(0),             W'(16'h0100), 1'b0};
      tbl[1] = '{AW'(HL_B_BASE),     W'(16'h0100), 1'b0};
      tbl[2] = '{AW'(OL_B_BASE),     W'(16'hFF00), 1'b0};
      tbl[3] = '{AW'(CFG_DEPTH),     W'(16'h1234), 1'b1};
      tbl[4] = '{AW'(CFG_DEPTH + 3), W'(16'h5555), 1'b1};
      tbl[5] = '{AW'(OL_W_BASE + 3), W'(16'h0007), 1'b0};
      tbl[6] = '{AW'(HL_W_BASE + 1), W'(16'hFFFD), 1'b0};
      tbl[7] = '{AW'(OL_B_BASE + 1), W'(16'h0020), 1'b0};

      // Reset state
      tick();
      tick();
      chk("rst_s_ready", wide_t'(s_ready), wide_t'(1));
      chk("rst_flags", wide_t'({busy, m_valid, net_valid_in, cfg_err, err_timeout}), wide_t'(0));
      chk("rst_cfg", dut_cfg(), wide_t'(0));
      chk("rst_data", in_pack() | m_pack(), wide_t'(0));
      rstn = 1'b1;
      tick();

      // Configuration table
      for (int i = 0; i < 8; i++) begin
         cfg_we    = 1'b1;
         cfg_addr  = tbl[i].addr;
         cfg_wdata = tbl[i].data;
         if (!tbl[i].err) sh[tbl[i].addr] = tbl[i].data;
         tick();
         cfg_we = 1'b0;
         chk($sformatf("cfg_err_%0d", i), wide_t'(cfg_err), wide_t'(tbl[i].err));
         chk($sformatf("cfg_readback_%0d", i), dut_cfg(), sh_pack());
      end
      tick();
      chk("cfg_err_idle", wide_t'(cfg_err), wide_t'(0));

      // Single inference, L=4
      lat = 4;
      launch(32'h0003_0005, 1'b1);
      chk("nvi_t1", wide_t'(net_valid_in), wide_t'(1));
      chk("busy_t1", wide_t'({busy, s_ready}), wide_t'(2'b10));
      chk("values_in_t1", in_pack(), wide_t'(32'h0003_0005));
      wait_mv(lat + 1, "single_latency");
      tick();
      chk("single_idle", wide_t'({busy, s_ready, m_valid}), wide_t'(3'b010));

      // Config write and handshake in the same IDLE cycle
      lat = 5;
      cfg_we = 1'b1;
      cfg_addr = AW'(OL_B_BASE);
      cfg_wdata = W'(16'h0040);
      sh[OL_B_BASE] = W'(16'h0040);
      launch(32'h0100_FFFF, 1'b1);
      cfg_we = 1'b0;
      chk("same_cycle_cfg_err", wide_t'(cfg_err), wide_t'(0));
      wait_mv(lat + 1, "same_cycle_latency");
      tick();

      // Back-to-back throughput with M_READY held high
      lat = 3;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (!s_ready && n < 60) begin
            tick();
            n++;
         end
         hs[k] = cyc;
         v = vec_t'($urandom);
         launch(v, 1'b1);
      end
      wait_mv(lat + 1, "tput_last");
      tick();
      chk("tput_gap0", wide_t'(hs[1] - hs[0]), wide_t'(lat + 3));
      chk("tput_gap1", wide_t'(hs[2] - hs[1]), wide_t'(lat + 3));

      // Output backpressure, spurious NET_VALID_OUT and a write during HOLD
      m_ready = 1'b0;
      lat = 3;
      v = 32'h0011_0022;
      expv = exp_res(v);
      launch(v, 1'b1);
      wait_mv(lat + 1, "bp_latency");
      for (int i = 0; i < 20; i++) begin
         chk("bp_m_valid", wide_t'({m_valid, s_ready}), wide_t'(2'b10));
         chk("bp_m_data", m_pack(), expv);
         if (i == 11) chk("hold_cfg_err", wide_t'(cfg_err), wide_t'(1));
         inject = (i == 4);
         cfg_we = (i == 10);
         cfg_addr = AW'(1);
         cfg_wdata = W'(16'h3333);
         tick();
      end
      inject = 1'b0;
      cfg_we = 1'b0;
      m_ready = 1'b1;
      tick();
      chk("bp_release", wide_t'({busy, s_ready, m_valid}), wide_t'(3'b010));
      chk("bp_cfg_unchanged", dut_cfg(), sh_pack());

      // Rejected write during WAIT
      lat = 6;
      launch(32'h0002_0001, 1'b1);
      tick();
      cfg_we = 1'b1;
      cfg_addr = AW'(0);
      cfg_wdata = W'(16'h7777);
      tick();
      cfg_we = 1'b0;
      chk("wait_cfg_err", wide_t'(cfg_err), wide_t'(1));
      chk("wait_cfg_unchanged", dut_cfg(), sh_pack());
      tick();
      chk("wait_cfg_err_pulse", wide_t'(cfg_err), wide_t'(0));
      wait_mv(lat - 2, "wait_write_latency");
      tick();

      // Timeout with no response
      lat = 0;
      mv = 0;
      launch(32'h0009_0009, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick();
         if (m_valid) mv++;
      end
      chk("to_before", wide_t'({err_timeout, busy}), wide_t'(2'b01));
      tick();
      chk("to_set", wide_t'({err_timeout, busy, s_ready}), wide_t'(3'b101));
      chk("to_no_m_valid", wide_t'(mv), wide_t'(0));
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("to_clear", wide_t'(err_timeout), wide_t'(0));

      // Result on the expiry cycle wins
      lat = 8;
      launch(32'h0004_0008, 1'b1);
      wait_mv(9, "to_edge_latency");
      tick();
      chk("to_edge_no_err", wide_t'(err_timeout), wide_t'(0));

      // One cycle too late: timeout, then late NET_VALID_OUT ignored in IDLE
      lat = 9;
      mv = 0;
      launch(32'h0004_0008, 1'b0);
      for (int i = 0; i < 9; i++) begin
         tick();
         if (m_valid) mv++;
      end
      chk("late_err", wide_t'(err_timeout), wide_t'(1));
      for (int i = 0; i < 5; i++) begin
         tick();
         if (m_valid) mv++;
      end
      chk("late_no_m_valid", wide_t'(mv), wide_t'(0));

      // ERR_CLEAR held through a new timeout: set wins
      lat = 0;
      err_clear = 1'b1;
      launch(32'h0001_0001, 1'b0);
      chk("sw_cleared", wide_t'(err_timeout), wide_t'(0));
      for (int i = 0; i < 9; i++) tick();
      chk("sw_set_wins", wide_t'(err_timeout), wide_t'(1));
      err_clear = 1'b0;
      tick();
      chk("sw_sticky", wide_t'(err_timeout), wide_t'(1));

      // Reset mid-WAIT, then a late response must be ignored
      lat = 6;
      launch(32'h0005_0006, 1'b0);
      tick();
      tick();
      rstn = 1'b0;
      #1;
      for (int i = 0; i < CFG_DEPTH; i++) sh[i] = '0;
      chk("mid_rst_s_ready", wide_t'(s_ready), wide_t'(1));
      chk("mid_rst_flags", wide_t'({busy, m_valid, net_valid_in, cfg_err, err_timeout}), wide_t'(0));
      chk("mid_rst_cfg", dut_cfg(), wide_t'(0));
      chk("mid_rst_data", in_pack() | m_pack(), wide_t'(0));
      tick();
      rstn = 1'b1;
      mv = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (m_valid) mv++;
      end
      chk("mid_rst_no_m_valid", wide_t'(mv), wide_t'(0));

      // Normal operation after reset
      lat = 2;
      launch(32'h0030_0040, 1'b1);
      wait_mv(lat + 1, "post_rst_latency");
      tick();
      tick();
      chk("sb_drained", wide_t'(sb.size()), wide_t'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
